// File: rtl/lau_pkg.sv
// lau_pkg: shared types and helpers for the arbitration blocks.
//   speed_e      - selects the prefix network structure (SLOW/MEDIUM/FAST)
//   arb_state_e  - round-robin arbiter FSM states
//   log2floor()  - floor(log2(n)) for elaboration-time sizing
package lau_pkg;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_e;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int log2floor(input int n);
    int r;
    r = 0;
    for (int i = 1; i < 32; i++) begin
      if ((n >> i) != 0) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_and.sv
// PrefixAnd: y[i] = &x[i:0] for every i.
//   width - vector width
//   speed - SLOW: serial ripple chain
//           MEDIUM: Sklansky (divide-and-conquer) network
//           FAST: Kogge-Stone network
// Ports:
//   x - input vector
//   y - inclusive prefix-AND of x
// All three structures compute the same function.
module PrefixAnd
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] x,
  output logic [width-1:0] y
);

  // Number of doubling levels needed to span width bits.
  localparam int LEVELS = log2floor(width - 1) + 1;

  if (speed == SLOW) begin : g_slow
    always_comb begin
      logic acc;
      acc = 1'b1;
      y   = '0;
      for (int i = 0; i < width; i++) begin
        acc  = acc & x[i];
        y[i] = acc;
      end
    end
  end else if (speed == MEDIUM) begin : g_medium
    always_comb begin
      logic [width-1:0] p;
      logic [width-1:0] n;
      p = x;
      n = x;
      for (int l = 0; l < LEVELS; l++) begin
        n = p;
        // Upper half of each 2^(l+1) block picks up the last bit of the
        // lower half, which is already complete for its block.
        for (int i = 0; i < width; i++) begin
          if (((i >> l) & 1) == 1) n[i] = p[i] & p[((i >> l) << l) - 1];
        end
        p = n;
      end
      y = p;
    end
  end else begin : g_fast
    always_comb begin
      logic [width-1:0] p;
      logic [width-1:0] n;
      p = x;
      n = x;
      for (int l = 0; l < LEVELS; l++) begin
        n = p;
        for (int i = 0; i < width; i++) begin
          if (i >= (1 << l)) n[i] = p[i] & p[i - (1 << l)];
        end
        p = n;
      end
      y = p;
    end
  end

endmodule

// File: rtl/prefix_rr_arbiter.sv
// prefix_rr_arbiter: registered round-robin arbiter built on prefix-AND
// lowest-set-bit searches.
// Handshake: valid_o/gnt_o/idx_o present a grant; a handshake happens on a
// rising edge where valid_o=1 and ready_i=1. While valid_o=1 and ready_i=0 the
// grant is held unchanged whatever req_i does. On a handshake a new grant may
// be registered in the same edge (one grant per cycle).
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   clear_i - synchronous clear to the reset state (highest priority)
//   req_i   - per-requester request vector
//   ready_i - consumer accepts the current grant
//   valid_o - grant presented
//   gnt_o   - one-hot grant, zero when valid_o=0
//   idx_o   - binary index of the granted requester
//   state_o - debug: FSM state (arb_state_e value, GRANT=1)
//   ptr_o   - debug: round-robin priority pointer
module prefix_rr_arbiter
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST,
  localparam int    IW    = $clog2(width)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [width-1:0] req_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [width-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             state_o,
  output logic [IW-1:0]    ptr_o
);

  arb_state_e       state_q, state_n;
  logic [width-1:0] gnt_q, gnt_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [IW-1:0]    ptr_q, ptr_n;

  logic [IW-1:0]    base;
  logic [width-1:0] mask;
  logic [width-1:0] req_m;
  logic [width-1:0] pa_m, pa_u;
  logic [width-1:0] sel_m, sel_u, sel;
  logic [IW-1:0]    sel_idx;

  // (v + 1) mod width, also correct for non-power-of-two widths.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == width - 1) ? '0 : v + 1'b1;
  endfunction

  // In GRANT the base only matters on a handshake, where the new pointer
  // would be idx+1; using that directly avoids a cycle of pointer latency.
  always_comb begin
    base = (state_q == GRANT) ? wrap_inc(idx_q) : ptr_q;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < width; i++) begin
      mask[i] = (i >= int'(base));
    end
  end

  assign req_m = req_i & mask;

  PrefixAnd #(.width(width), .speed(speed)) u_pa_masked (
    .x (~req_m),
    .y (pa_m)
  );

  PrefixAnd #(.width(width), .speed(speed)) u_pa_unmasked (
    .x (~req_i),
    .y (pa_u)
  );

  // Shifted prefix bit i is 1 when no request is set below i, so ANDing it
  // with the request keeps only the lowest set bit.
  assign sel_m = req_m & {pa_m[width-2:0], 1'b1};
  assign sel_u = req_i & {pa_u[width-2:0], 1'b1};
  assign sel   = (|sel_m) ? sel_m : sel_u;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < width; i++) begin
      if (sel[i]) sel_idx = sel_idx | IW'(i);
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    ptr_n   = ptr_q;
    if (clear_i) begin
      state_n = IDLE;
      gnt_n   = '0;
      idx_n   = '0;
      ptr_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_n = GRANT;
            gnt_n   = sel;
            idx_n   = sel_idx;
          end
        end
        GRANT: begin
          if (ready_i) begin
            ptr_n = wrap_inc(idx_q);
            if (|req_i) begin
              gnt_n = sel;
              idx_n = sel_idx;
            end else begin
              state_n = IDLE;
              gnt_n   = '0;
              idx_n   = '0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
          ptr_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
      ptr_q   <= ptr_n;
    end
  end

  assign valid_o = (state_q == GRANT);
  assign gnt_o   = gnt_q;
  assign idx_o   = idx_q;
  assign state_o = state_q;
  assign ptr_o   = ptr_q;

endmodule

// File: tb/tb_prefix_rr_arbiter.sv
// Testbench for prefix_rr_arbiter (width=4): SLOW, MEDIUM and FAST instances
// run in lockstep against a round-robin reference model via a scoreboard.
module tb_prefix_rr_arbiter;
  import lau_pkg::*;

  localparam int W  = 4;
  localparam int IW = 2;
  localparam int EW = 1 + IW + 1 + IW + W;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic [W-1:0] req_i;
  logic         ready_i;

  logic          valid_s, valid_m, valid_f;
  logic [W-1:0]  gnt_s, gnt_m, gnt_f;
  logic [IW-1:0] idx_s, idx_m, idx_f;
  logic          state_s, state_m, state_f;
  logic [IW-1:0] ptr_s, ptr_m, ptr_f;

  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  prefix_rr_arbiter #(.width(W), .speed(SLOW)) u_slow (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .ready_i(ready_i),
    .valid_o(valid_s), .gnt_o(gnt_s), .idx_o(idx_s), .state_o(state_s), .ptr_o(ptr_s)
  );
  prefix_rr_arbiter #(.width(W), .speed(MEDIUM)) u_medium (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .ready_i(ready_i),
    .valid_o(valid_m), .gnt_o(gnt_m), .idx_o(idx_m), .state_o(state_m), .ptr_o(ptr_m)
  );
  prefix_rr_arbiter #(.width(W), .speed(FAST)) u_fast (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .ready_i(ready_i),
    .valid_o(valid_f), .gnt_o(gnt_f), .idx_o(idx_f), .state_o(state_f), .ptr_o(ptr_f)
  );

  // ---------------- reference model ----------------
  // Round robin: first requester found scanning upward from base, wrapping.
  function automatic int pick(input logic [W-1:0] r, input int base);
    for (int k = 0; k < W; k++) begin
      int c;
      c = (base + k) % W;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic rdy, input logic clr);
    if (clr) begin
      model_reset();
    end else if (!m_valid) begin
      if (r != 0) begin
        m_valid = 1'b1;
        m_idx   = pick(r, m_ptr);
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % W;
      if (r != 0) begin
        m_idx = pick(r, m_ptr);
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end
  endtask

  function automatic logic [EW-1:0] pack_exp();
    logic [W-1:0] g;
    g = m_valid ? W'(1 << m_idx) : '0;
    return {m_valid, IW'(m_ptr), m_valid, IW'(m_idx), g};
  endfunction

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [EW-1:0] got, input logic [EW-1:0] e);
    n_vec++;
    if (got !== e) begin
      n_miss++;
      $display("FAIL %s: got {state,ptr,valid,idx,gnt}=%b expected %b at %0t", name, got, e, $time);
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] e);
    n_vec++;
    if (got !== e) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, e, $time);
    end
  endtask

  // monitor: one expectation per clock edge that had stimulus behind it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      cmp("slow",   {state_s, ptr_s, valid_s, idx_s, gnt_s}, e);
      cmp("medium", {state_m, ptr_m, valid_m, idx_m, gnt_m}, e);
      cmp("fast",   {state_f, ptr_f, valid_f, idx_f, gnt_f}, e);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [W-1:0] r, input logic rdy, input logic clr);
    @(negedge clk);
    req_i   = r;
    ready_i = rdy;
    clear_i = clr;
    model_step(r, rdy, clr);
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #2;
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
  endtask

  initial begin
    #1_000_000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] fair_tbl [5];
    fair_tbl[0] = 4'b0001;
    fair_tbl[1] = 4'b0010;
    fair_tbl[2] = 4'b0100;
    fair_tbl[3] = 4'b1000;
    fair_tbl[4] = 4'b0001;

    rst_ni  = 1'b0;
    clear_i = 1'b0;
    req_i   = '0;
    ready_i = 1'b0;
    model_reset();
    #3;
    check("reset_valid", 16'(valid_f), 16'h0);
    check("reset_gnt",   16'(gnt_f),   16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // fairness: all requesting, always ready
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      check("fair_gnt", 16'(gnt_f), 16'(fair_tbl[i]));
    end

    // handshake with no requests -> idle, pointer past last grant (0)
    step(4'b0000, 1'b1, 1'b0);
    check("idle_valid", 16'(valid_f), 16'h0);
    check("idle_ptr",   16'(ptr_f),   16'h1);

    // stall: grant held while ready low, even after req[0] withdraws
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0);
    check("stall_first", 16'(gnt_f), 16'h1);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    check("stall_hold", 16'(gnt_f), 16'h1);
    step(4'b0100, 1'b1, 1'b0);
    check("stall_next", 16'(gnt_f), 16'h4);

    // wrap: grant index 3, then pointer wraps to 0
    step(4'b1000, 1'b1, 1'b0);
    check("wrap_idx3", 16'(idx_f), 16'h3);
    step(4'b0110, 1'b1, 1'b0);
    check("wrap_ptr", 16'(ptr_f), 16'h0);
    check("wrap_gnt", 16'(gnt_f), 16'h2);

    // clear during grant
    step(4'b1111, 1'b1, 1'b1);
    check("clear_state", 16'(state_f), 16'(IDLE));
    check("clear_ptr",   16'(ptr_f),   16'h0);

    // asynchronous reset mid-grant
    step(4'b0100, 1'b0, 1'b0);
    check("pre_rst_gnt", 16'(gnt_f), 16'h4);
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_gnt_fast",   16'(gnt_f),   16'h0);
    check("arst_valid_fast", 16'(valid_f), 16'h0);
    check("arst_gnt_slow",   16'(gnt_s),   16'h0);
    check("arst_gnt_med",    16'(gnt_m),   16'h0);
    model_reset();
    req_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step(4'b1111, 1'b0, 1'b0);
    check("post_rst_gnt", 16'(gnt_f), 16'h1);

    // random lockstep run
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] r;
      logic         rdy;
      logic         clr;
      r   = W'($urandom_range(0, 15));
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) == 0);
      step(r, rdy, clr);
    end

    check("queue_drained", 16'(exp_q.size()), 16'h0);
    summary();
    $finish;
  end

endmodule
